// File: rtl/input_sequencer_if.sv
// rtl/input_sequencer_if.sv - handshake bundle between the game FSM / PS/2 framer and input_sequencer
//
// Purpose: groups the control pulses, scan byte stream and entry result of
//          input_sequencer into one bundle.
// Signals:
//   start        game FSM -> sequencer, opens a new entry (1-cycle pulse)
//   code_valid   framer -> sequencer, framed scan byte present on code
//   code[7:0]    scan byte
//   ack          consumer accepts the completed entry
//   busy         sequencer collecting (COLLECT or BREAK)
//   entry_valid  completed entry available (DONE)
//   entry[15:0]  packed BCD digits, first digit in [3:0]
//   digit_count  number of digits stored (0..4)
//   timed_out    entry was closed by the idle timeout
//   err          1-cycle pulse on an unrecognised make code
// Modports: master = stimulus/consumer side, slave = sequencer.

interface input_sequencer_if;
  logic        start;
  logic        code_valid;
  logic [7:0]  code;
  logic        ack;
  logic        busy;
  logic        entry_valid;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        timed_out;
  logic        err;

  modport master (
    output start, code_valid, code, ack,
    input  busy, entry_valid, entry, digit_count, timed_out, err
  );

  modport slave (
    input  start, code_valid, code, ack,
    output busy, entry_valid, entry, digit_count, timed_out, err
  );
endinterface

// File: rtl/input_sequencer.sv
// rtl/input_sequencer.sv - collects up to four PS/2 keypad digits into a packed BCD entry
//
// Purpose: after a start pulse, decodes PS/2 make codes into BCD digits and
//          packs them in arrival order. The entry closes after the fourth
//          digit or after TIMEOUT idle cycles, and is held until ack.
//          Break (F0) sequences skip their following byte; E0 prefixes are
//          dropped; unknown make codes pulse err.
// Parameters: TIMEOUT (idle cycles before close), TW (timer width).
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  input_sequencer_if.slave (see interface file for signal list)
// Optional feature: macro BACKSPACE_EN makes scan code 66 delete the last digit.

module input_sequencer #(
  parameter int TIMEOUT = 100_000_000,
  parameter int TW      = 27
) (
  input  logic               clk,
  input  logic               rst,
  input_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    BREAK   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [15:0]   entry_q, entry_d;
  logic [2:0]    count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          timed_out_q, timed_out_d;
  logic          err_q, err_d;
  logic [4:0]    digit;

  // {is_digit, bcd} for a make code
  function automatic logic [4:0] decode_digit(input logic [7:0] b);
    logic [4:0] r;
    case (b)
      8'h16:   r = {1'b1, 4'd1};
      8'h1E:   r = {1'b1, 4'd2};
      8'h26:   r = {1'b1, 4'd3};
      8'h25:   r = {1'b1, 4'd4};
      8'h2E:   r = {1'b1, 4'd5};
      8'h36:   r = {1'b1, 4'd6};
      8'h3D:   r = {1'b1, 4'd7};
      8'h3E:   r = {1'b1, 4'd8};
      8'h46:   r = {1'b1, 4'd9};
      8'h45:   r = {1'b1, 4'd0};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] put_nibble(input logic [15:0] e,
                                             input logic [1:0]  slot,
                                             input logic [3:0]  n);
    logic [15:0] r;
    r = e;
    case (slot)
      2'd0: r[3:0]   = n;
      2'd1: r[7:4]   = n;
      2'd2: r[11:8]  = n;
      2'd3: r[15:12] = n;
      default: r = e;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      entry_q     <= 16'd0;
      count_q     <= 3'd0;
      timer_q     <= '0;
      timed_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      timed_out_q <= timed_out_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    count_d     = count_q;
    timer_d     = timer_q;
    timed_out_d = timed_out_q;
    err_d       = 1'b0;
    digit       = decode_digit(bus.code);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = COLLECT;
          entry_d     = 16'd0;
          count_d     = 3'd0;
          timer_d     = '0;
          timed_out_d = 1'b0;
        end
      end

      COLLECT: begin
        // A byte always wins over a coincident timer expiry.
        if (bus.code_valid) begin
          timer_d = '0;
          if (bus.code == 8'hF0) begin
            state_d = BREAK;
          end else if (bus.code == 8'hE0) begin
            state_d = COLLECT;
          end
`ifdef BACKSPACE_EN
          else if (bus.code == 8'h66) begin
            if (count_q != 3'd0) begin
              count_d = count_q - 3'd1;
              entry_d = put_nibble(entry_q, count_q[1:0] - 2'd1, 4'd0);
            end
          end
`endif
          else if (digit[4]) begin
            entry_d = put_nibble(entry_q, count_q[1:0], digit[3:0]);
            count_d = count_q + 3'd1;
            if (count_q == 3'd3) state_d = DONE;
          end else begin
            err_d = 1'b1;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      BREAK: begin
        // The byte after F0 is the released key; drop it silently.
        if (bus.code_valid) begin
          timer_d = '0;
          state_d = COLLECT;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      DONE: begin
        if (bus.ack) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = (state_q == COLLECT) || (state_q == BREAK);
  assign bus.entry_valid = (state_q == DONE);
  assign bus.entry       = entry_q;
  assign bus.digit_count = count_q;
  assign bus.timed_out   = timed_out_q;
  assign bus.err         = err_q;

endmodule
